// File: rtl/csr_arb_pkg.sv
// Shared types and constants for the CSR access arbiter: FSM state encoding
// and the default first-illegal CSR address.
package csr_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    localparam logic [7:0] CSR_LIMIT_DEFAULT = 8'h80;

endpackage

// File: rtl/csr_access_arbiter_rr.sv
// Combinational round-robin picker: one-hot grant to the first requester found
// when searching upward from ptr_i, wrapping at NUM_REQ-1.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o
);

    int ptr_s;
    int off_s;
    int best_off_s;
    int best_s;

    // Rank each request by its distance from the pointer; the smallest distance wins
    always_comb begin
        ptr_s      = int'(ptr_i);
        off_s      = 0;
        best_off_s = NUM_REQ;
        best_s     = 0;
        grant_o    = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (j >= ptr_s) begin
                off_s = j - ptr_s;
            end else begin
                off_s = j + NUM_REQ - ptr_s;
            end
            if (req_i[j] && (off_s < best_off_s)) begin
                best_off_s = off_s;
                best_s     = j;
            end else begin
                best_s     = best_s;
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            grant_o[j] = (best_off_s < NUM_REQ) && (best_s == j);
        end
    end

endmodule

// File: rtl/csr_access_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single CSR port, one transaction at a
// time: grant (IDLE) -> single-cycle strobe (ISSUE) -> held response (RESP).
module csr_access_arbiter
    import csr_arb_pkg::*;
#(
    parameter int CSR_ADDR_WIDTH = 8,
    parameter int CSR_DATA_WIDTH = 32,
    parameter int NUM_REQ        = 2,
    parameter logic [CSR_ADDR_WIDTH-1:0] CSR_LIMIT = CSR_ADDR_WIDTH'(CSR_LIMIT_DEFAULT)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*CSR_ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*CSR_DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [CSR_DATA_WIDTH-1:0]          rsp_rdata,
    output logic                               rsp_err,
    output logic                               csr_wen,
    output logic                               csr_ren,
    output logic [CSR_ADDR_WIDTH-1:0]          csr_addr,
    output logic [CSR_DATA_WIDTH-1:0]          csr_wdata,
    input  logic [CSR_DATA_WIDTH-1:0]          csr_rdata,
    output logic                               busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_e                state_q, state_d;
    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]          idx_q, idx_d;
    logic                      write_q, write_d;
    logic [CSR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CSR_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CSR_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                      err_q, err_d;

    logic [NUM_REQ-1:0]        grant_s;
    logic [PTR_W-1:0]          gidx_s;
    logic                      sel_write_s;
    logic [CSR_ADDR_WIDTH-1:0] sel_addr_s;
    logic [CSR_DATA_WIDTH-1:0] sel_wdata_s;
    logic                      rsp_ack_s;
    logic                      in_range_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_s)
    );

    assign in_range_s = (addr_q < CSR_LIMIT);

    // Select the winner's fields; grant is one-hot so OR-accumulation is exact
    always_comb begin
        gidx_s      = '0;
        sel_write_s = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        rsp_ack_s   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gidx_s      = gidx_s | (grant_s[i] ? PTR_W'(i) : '0);
            sel_write_s = sel_write_s | (grant_s[i] & req_write[i]);
            sel_addr_s  = sel_addr_s | (grant_s[i] ? req_addr[i*CSR_ADDR_WIDTH +: CSR_ADDR_WIDTH] : '0);
            sel_wdata_s = sel_wdata_s | (grant_s[i] ? req_wdata[i*CSR_DATA_WIDTH +: CSR_DATA_WIDTH] : '0);
            rsp_ack_s   = rsp_ack_s | ((idx_q == PTR_W'(i)) & rsp_ready[i]);
        end
    end

    // Next-state logic: latch on grant, resolve the access in ISSUE, wait for handshake in RESP
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        idx_d    = idx_q;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    idx_d    = gidx_s;
                    write_d  = sel_write_s;
                    addr_d   = sel_addr_s;
                    wdata_d  = sel_wdata_s;
                    rr_ptr_d = (gidx_s == PTR_W'(NUM_REQ - 1)) ? '0 : gidx_s + PTR_W'(1);
                    state_d  = ST_ISSUE;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (in_range_s) begin
                    err_d   = 1'b0;
                    rdata_d = write_q ? '0 : csr_rdata;
                end else begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ack_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and transaction latch; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            idx_q    <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            idx_q    <= idx_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Output decode; rst_n gates the grant because the picker alone sees raw requests
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        csr_wen   = 1'b0;
        csr_ren   = 1'b0;
        if ((state_q == ST_IDLE) && rst_n) begin
            req_ready = grant_s;
        end else begin
            req_ready = '0;
        end
        if ((state_q == ST_ISSUE) && in_range_s) begin
            csr_wen = write_q;
            csr_ren = !write_q;
        end else begin
            csr_wen = 1'b0;
            csr_ren = 1'b0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = (state_q == ST_RESP) && (idx_q == PTR_W'(i));
        end
    end

    assign csr_addr  = addr_q;
    assign csr_wdata = wdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Bench for csr_access_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_csr_access_arbiter;

    localparam int N     = 2;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int LIMIT = 128;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            csr_wen;
    logic            csr_ren;
    logic [AW-1:0]   csr_addr;
    logic [DW-1:0]   csr_wdata;
    logic [DW-1:0]   csr_rdata = '0;
    logic            busy;

    int total = 0;
    int bad = 0;
    int wen_cnt = 0;
    int ren_cnt = 0;

    // Reference model: age 0 = free, 1 = strobe cycle, 2 = response pending
    int            m_age = 0;
    int            m_ptr = 0;
    int            m_idx = 0;
    logic          m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    logic          m_err = 1'b0;

    csr_access_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .csr_wen   (csr_wen),
        .csr_ren   (csr_ren),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_rdata (csr_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Model update on each rising edge, cleared by reset at any time
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_age = 0; m_ptr = 0; m_idx = 0; m_wr = 1'b0;
                m_addr = '0; m_wdata = '0; m_rdata = '0; m_err = 1'b0;
            end else if (m_age == 0) begin
                int g;
                g = pick(req_valid, m_ptr);
                if (g >= 0) begin
                    m_idx   = g;
                    m_wr    = req_write[g];
                    m_addr  = req_addr[g*AW +: AW];
                    m_wdata = req_wdata[g*DW +: DW];
                    m_ptr   = (g + 1) % N;
                    m_age   = 1;
                end
            end else if (m_age == 1) begin
                m_err   = (int'(m_addr) >= LIMIT);
                m_rdata = (m_err || m_wr) ? '0 : csr_rdata;
                m_age   = 2;
            end else begin
                if (rsp_ready[m_idx]) m_age = 0;
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_req_ready", req_ready, 0);
                chk("rst_rsp_valid", rsp_valid, 0);
                chk("rst_rsp_err", rsp_err, 0);
                chk("rst_rsp_rdata", rsp_rdata, 0);
                chk("rst_strobes", {csr_wen, csr_ren}, 0);
                chk("rst_busy", busy, 0);
                chk("rst_csr_addr", csr_addr, 0);
                chk("rst_csr_wdata", csr_wdata, 0);
            end else begin
                int g;
                logic [N-1:0] one;
                one = 1;
                g = pick(req_valid, m_ptr);
                chk("busy", busy, m_age != 0);
                chk("req_ready", req_ready, (m_age == 0 && g >= 0) ? (one << g) : 0);
                chk("csr_wen", csr_wen, m_age == 1 && int'(m_addr) < LIMIT && m_wr);
                chk("csr_ren", csr_ren, m_age == 1 && int'(m_addr) < LIMIT && !m_wr);
                chk("csr_addr", csr_addr, m_addr);
                chk("csr_wdata", csr_wdata, m_wdata);
                chk("rsp_valid", rsp_valid, (m_age == 2) ? (one << m_idx) : 0);
                if (m_age == 2) begin
                    chk("rsp_rdata", rsp_rdata, m_rdata);
                    chk("rsp_err", rsp_err, m_err);
                end
            end
            if (csr_wen) wen_cnt++;
            if (csr_ren) ren_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i] = 1'b1;
        req_write[i] = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    initial begin
        int wen0;
        int ren0;
        int q[$];
        int gcyc[$];

        repeat (3) step();
        @(negedge clk);
        chk("lit_reset_busy", busy, 0);
        chk("lit_reset_csr_addr", csr_addr, 0);
        step();
        rst_n = 1'b1;

        // Single write from requester 0
        wen0 = wen_cnt;
        set_req(0, 1'b1, 8'h10, 32'hDEADBEEF);
        @(negedge clk); chk("wr_grant", req_ready, 2'b01);
        step(); req_valid = '0;
        @(negedge clk);
        chk("wr_wen", csr_wen, 1); chk("wr_addr", csr_addr, 8'h10); chk("wr_wdata", csr_wdata, 32'hDEADBEEF);
        step();
        @(negedge clk);
        chk("wr_rsp_valid", rsp_valid, 2'b01); chk("wr_rsp_err", rsp_err, 0); chk("wr_wen_gone", csr_wen, 0);
        rsp_ready = 2'b01; step(); rsp_ready = '0;
        @(negedge clk); #1;
        chk("wr_wen_count", wen_cnt - wen0, 1); chk("wr_idle", busy, 0);

        // Single read from requester 1, response held for 5 cycles
        step();
        ren0 = ren_cnt;
        csr_rdata = 32'h12345678;
        set_req(1, 1'b0, 8'h04, 32'h0);
        @(negedge clk); chk("rd_grant", req_ready, 2'b10);
        step(); req_valid = '0;
        @(negedge clk); chk("rd_ren", csr_ren, 1);
        step(); csr_rdata = 32'hFFFF0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rd_hold_data", rsp_rdata, 32'h12345678);
            chk("rd_hold_valid", rsp_valid, 2'b10);
            step();
        end
        rsp_ready = 2'b10; step(); rsp_ready = '0;
        @(negedge clk); #1;
        chk("rd_ren_count", ren_cnt - ren0, 1); chk("rd_idle", busy, 0);

        // Illegal address, then the last legal word
        step();
        wen0 = wen_cnt;
        set_req(0, 1'b1, 8'h80, 32'h55);
        @(negedge clk); chk("ill_grant", req_ready, 2'b01);
        step(); req_valid = '0;
        @(negedge clk); chk("ill_no_wen", csr_wen, 0);
        step();
        @(negedge clk); chk("ill_err", rsp_err, 1); chk("ill_rdata", rsp_rdata, 0);
        rsp_ready = 2'b01; step(); rsp_ready = '0;
        set_req(0, 1'b1, 8'h7C, 32'hA5A5A5A5);
        @(negedge clk); chk("lim_grant", req_ready, 2'b01);
        step(); req_valid = '0;
        @(negedge clk); chk("lim_wen", csr_wen, 1); chk("lim_addr", csr_addr, 8'h7C);
        step();
        @(negedge clk); chk("lim_err", rsp_err, 0);
        rsp_ready = 2'b01; step(); rsp_ready = '0;
        @(negedge clk); #1; chk("ill_wen_count", wen_cnt - wen0, 1);

        // Contention from reset: both valid, responses accepted at once
        step(); rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        set_req(0, 1'b1, 8'h20, 32'h1); set_req(1, 1'b1, 8'h24, 32'h2);
        rsp_ready = 2'b11;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req_ready == 2'b01) q.push_back(0);
            if (req_ready == 2'b10) q.push_back(1);
            step();
        end
        chk("rr_grant_count", q.size(), 4);
        for (int k = 0; k < 4; k++) chk("rr_order", (k < q.size()) ? q[k] : -1, k % 2);

        // Back-to-back single requester
        req_valid = 2'b01;
        wen0 = wen_cnt;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (req_ready != 0) gcyc.push_back(c);
            step();
        end
        req_valid = '0;
        @(negedge clk); #1;
        chk("b2b_count", gcyc.size(), 3);
        for (int k = 0; k < gcyc.size(); k++) chk("b2b_cycle", gcyc[k], 3 * k);
        chk("b2b_strobes", wen_cnt - wen0, 3);

        // Reset while requester 1's response is pending
        step(); rsp_ready = '0;
        set_req(0, 1'b0, 8'h08, 32'h0); set_req(1, 1'b0, 8'h0C, 32'h0);
        @(negedge clk); chk("rstr_grant", req_ready, 2'b10);
        step(); req_valid = '0;
        step();
        @(negedge clk); chk("rstr_valid", rsp_valid, 2'b10);
        step(); req_valid = 2'b11; rst_n = 1'b0; #1;
        chk("rstr_now_valid", rsp_valid, 0); chk("rstr_now_ready", req_ready, 0);
        chk("rstr_now_busy", busy, 0); chk("rstr_now_rdata", rsp_rdata, 0);
        step(); rst_n = 1'b1;
        @(negedge clk); chk("rstr_regrant", req_ready, 2'b01);

        // Reset during the strobe cycle of a grant to 0: pointer must return to 0
        step(); req_valid = '0; rst_n = 1'b0; #1;
        chk("rsti_no_ren", csr_ren, 0);
        step(); rst_n = 1'b1; req_valid = 2'b11;
        @(negedge clk); chk("rsti_ptr0", req_ready, 2'b01);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            step();
            rst_n     = ($urandom_range(0, 79) != 0);
            req_valid = N'($urandom);
            req_write = N'($urandom);
            req_addr  = (N*AW)'($urandom);
            req_wdata = {$urandom, $urandom};
            rsp_ready = N'($urandom);
            csr_rdata = $urandom;
        end
        step();
        rst_n = 1'b1; req_valid = '0; rsp_ready = '1;
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
